// File: rtl/mem_write_arbiter.sv
// Two-requester round-robin arbiter that packs accepted words into a paged write
// memory, keeping a saturating per-page entry count and a sticky overflow flag.
module mem_write_arbiter #(
   parameter int RAM_WIDTH = 18,
   parameter int PAGE_BITS = 3,
   parameter int ENT_BITS  = 7
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              bx_start,
   input  logic                              in0_valid,
   input  logic [RAM_WIDTH-1:0]              in0_data,
   output logic                              in0_ready,
   input  logic                              in1_valid,
   input  logic [RAM_WIDTH-1:0]              in1_data,
   output logic                              in1_ready,
   output logic                              mem_wea,
   output logic [PAGE_BITS+ENT_BITS-1:0]     mem_addra,
   output logic [RAM_WIDTH-1:0]              mem_dina,
   output logic [(1<<PAGE_BITS)-1:0]         nent_we,
   output logic [8*(1<<PAGE_BITS)-1:0]       nent_i,
   output logic [PAGE_BITS-1:0]              page_o,
   output logic                              overflow
);

   localparam int NPAGES = 1 << PAGE_BITS;

   logic [PAGE_BITS-1:0]          page_reg;
   logic [ENT_BITS:0]             cnt_reg [NPAGES];
   logic                          rr_reg;
   logic                          overflow_reg;
   logic                          wea_reg;
   logic [PAGE_BITS+ENT_BITS-1:0] addr_reg;
   logic [RAM_WIDTH-1:0]          dina_reg;
   logic [NPAGES-1:0]             nent_we_reg;

   logic                          sel1;
   logic                          xfer;
   logic [RAM_WIDTH-1:0]          xfer_data;
   logic [PAGE_BITS-1:0]          page_inc;
   logic [ENT_BITS:0]             cur_cnt;
   logic                          page_full;
   logic [NPAGES-1:0]             cur_onehot;
   logic [NPAGES-1:0]             inc_onehot;

   // rr_reg=1 favours in1; a lone valid requester overrides the pointer.
   always_comb begin
      sel1 = rr_reg;
      if (in0_valid && !in1_valid)
         sel1 = 1'b0;
      else if (in1_valid && !in0_valid)
         sel1 = 1'b1;
      in0_ready  = rst_n & ~bx_start & ~sel1;
      in1_ready  = rst_n & ~bx_start & sel1;
      xfer       = (in0_ready & in0_valid) | (in1_ready & in1_valid);
      xfer_data  = sel1 ? in1_data : in0_data;
      page_inc   = page_reg + 1'b1;
      cur_cnt    = cnt_reg[page_reg];
      page_full  = cur_cnt[ENT_BITS];
      cur_onehot = {{(NPAGES-1){1'b0}}, 1'b1} << page_reg;
      inc_onehot = {{(NPAGES-1){1'b0}}, 1'b1} << page_inc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         page_reg     <= '0;
         rr_reg       <= 1'b0;
         overflow_reg <= 1'b0;
         wea_reg      <= 1'b0;
         addr_reg     <= '0;
         dina_reg     <= '0;
         nent_we_reg  <= '0;
      end else begin
         wea_reg     <= 1'b0;
         nent_we_reg <= '0;
         if (bx_start) begin
            page_reg     <= page_inc;
            overflow_reg <= 1'b0;
            nent_we_reg  <= inc_onehot;
         end else if (xfer) begin
            rr_reg <= ~sel1;
            if (!page_full) begin
               wea_reg     <= 1'b1;
               addr_reg    <= {page_reg, cur_cnt[ENT_BITS-1:0]};
               dina_reg    <= xfer_data;
               nent_we_reg <= cur_onehot;
            end else begin
               overflow_reg <= 1'b1;
            end
         end
      end
   end

   // Counters saturate at 2^ENT_BITS; a full page silently drops further words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NPAGES; i++)
            cnt_reg[i] <= '0;
      end else if (bx_start) begin
         cnt_reg[page_inc] <= '0;
      end else if (xfer && !page_full) begin
         cnt_reg[page_reg] <= cur_cnt + 1'b1;
      end
   end

   for (genvar gi = 0; gi < NPAGES; gi++) begin : g_nent
      assign nent_i[8*gi +: 8] = 8'(cnt_reg[gi]);
   end

   assign mem_wea   = wea_reg;
   assign mem_addra = addr_reg;
   assign mem_dina  = dina_reg;
   assign nent_we   = nent_we_reg;
   assign page_o    = page_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Randomized and directed bench for mem_write_arbiter against a page/count reference model.
module tb_mem_write_arbiter;

   localparam int RW = 18;
   localparam int PB = 3;
   localparam int EB = 7;
   localparam int NP = 1 << PB;
   localparam int CAP = 1 << EB;

   logic            clk;
   logic            rst_n;
   logic            bx_start;
   logic            in0_valid, in1_valid;
   logic [RW-1:0]   in0_data, in1_data;
   logic            in0_ready, in1_ready;
   logic            mem_wea;
   logic [PB+EB-1:0] mem_addra;
   logic [RW-1:0]   mem_dina;
   logic [NP-1:0]   nent_we;
   logic [8*NP-1:0] nent_i;
   logic [PB-1:0]   page_o;
   logic            overflow;

   mem_write_arbiter #(.RAM_WIDTH(RW), .PAGE_BITS(PB), .ENT_BITS(EB)) dut (
      .clk(clk), .rst_n(rst_n), .bx_start(bx_start),
      .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
      .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
      .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
      .nent_we(nent_we), .nent_i(nent_i), .page_o(page_o), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: page number, entry counts, who won last, overflow flag.
   int m_page;
   int m_cnt [NP];
   int m_last;
   bit m_ovf;
   bit e_wea;
   int e_addr;
   logic [RW-1:0] e_din;
   logic [NP-1:0] e_we;
   bit obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1;

   task automatic model_reset();
      m_page = 0;
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
      m_last = 1;
      m_ovf = 0;
      e_wea = 0;
      e_addr = 0;
      e_din = '0;
      e_we = '0;
   endtask

   function automatic logic [8*NP-1:0] model_nent();
      logic [8*NP-1:0] v;
      for (int p = 0; p < NP; p++) v[8*p +: 8] = 8'(m_cnt[p]);
      return v;
   endfunction

   // Drives one cycle of inputs, samples ready, advances the model and the clock.
   task automatic cycle(input logic bx, input logic v0, input logic [RW-1:0] d0,
                        input logic v1, input logic [RW-1:0] d1);
      int w;
      bit took;
      bx_start = bx; in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1;
      #1;
      obs_rdy0 = in0_ready;
      obs_rdy1 = in1_ready;
      if (v0 && v1) w = 1 - m_last;
      else if (v0) w = 0;
      else if (v1) w = 1;
      else w = 1 - m_last;
      exp_rdy0 = !bx && (w == 0);
      exp_rdy1 = !bx && (w == 1);
      took = !bx && ((w == 0 && v0) || (w == 1 && v1));
      e_wea = 0;
      e_we = '0;
      if (bx) begin
         m_page = (m_page + 1) % NP;
         m_cnt[m_page] = 0;
         m_ovf = 0;
         e_we[m_page] = 1'b1;
      end else if (took) begin
         m_last = w;
         if (m_cnt[m_page] < CAP) begin
            e_wea = 1;
            e_addr = m_page * CAP + m_cnt[m_page];
            e_din = (w == 0) ? d0 : d1;
            e_we[m_page] = 1'b1;
            m_cnt[m_page] = m_cnt[m_page] + 1;
         end else begin
            m_ovf = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bx_start = 0; in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0;
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      bx_start = 0; in0_valid = 1; in1_valid = 1; in0_data = 18'h1; in1_data = 18'h2;
      rst_n = 1'b0;
      #3;
      n_cmp++; if ({in0_ready, in1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {in0_ready, in1_ready}); end
      @(posedge clk); #1;
      n_cmp++; if (mem_wea !== 1'b0 || nent_we !== '0) begin n_fail++; $display("FAIL reset_we got wea=%b nent_we=%h exp 0/0", mem_wea, nent_we); end
      n_cmp++; if (mem_addra !== '0 || mem_dina !== '0) begin n_fail++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", mem_addra, mem_dina); end
      n_cmp++; if (nent_i !== '0 || page_o !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_state got nent=%h page=%0d ovf=%b exp 0", nent_i, page_o, overflow); end
      rst_n = 1'b1;
      model_reset();
      in0_valid = 0; in1_valid = 0;
      #1;
      n_cmp++; if ({in0_ready, in1_ready} !== 2'b10) begin n_fail++; $display("FAIL reset_rr got=%b exp=10", {in0_ready, in1_ready}); end
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      cycle(1'b0, 1'b1, 18'h00A5, 1'b0, 18'h0);
      n_cmp++; if (obs_rdy0 !== 1'b1 || obs_rdy1 !== 1'b0) begin n_fail++; $display("FAIL single_ready got=%b%b exp=10", obs_rdy0, obs_rdy1); end
      n_cmp++; if (mem_wea !== 1'b1 || mem_addra !== '0 || mem_dina !== 18'h00A5) begin n_fail++; $display("FAIL single_write got wea=%b addr=%h din=%h exp 1/0/a5", mem_wea, mem_addra, mem_dina); end
      n_cmp++; if (nent_we !== 8'b0000_0001 || nent_i[7:0] !== 8'd1) begin n_fail++; $display("FAIL single_nent got we=%b cnt=%0d exp 00000001/1", nent_we, nent_i[7:0]); end
      cycle(1'b0, 1'b0, 18'h0, 1'b0, 18'h0);
      n_cmp++; if (mem_wea !== 1'b0 || nent_we !== '0) begin n_fail++; $display("FAIL single_idle got wea=%b we=%b exp 0/0", mem_wea, nent_we); end
      $display("test_single done");
   endtask

   task automatic test_alternate();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 18'h1, 1'b1, 18'h2);
         n_cmp++; if (mem_wea !== 1'b1 || mem_addra !== 10'(i) || mem_dina !== ((i % 2 == 0) ? 18'h1 : 18'h2)) begin n_fail++; $display("FAIL alt_write%0d got wea=%b addr=%0d din=%h exp 1/%0d/%0d", i, mem_wea, mem_addra, mem_dina, i, (i % 2) + 1); end
      end
      n_cmp++; if (nent_i[7:0] !== 8'd4) begin n_fail++; $display("FAIL alt_count got=%0d exp=4", nent_i[7:0]); end
      $display("test_alternate done");
   endtask

   task automatic test_overflow();
      logic [RW-1:0] d;
      do_reset();
      for (int i = 0; i < 130; i++) begin
         d = 18'($urandom);
         cycle(1'b0, 1'b1, d, 1'b0, 18'h0);
         if (i < CAP) begin
            n_cmp++; if (mem_wea !== 1'b1 || mem_addra !== 10'(i) || mem_dina !== d) begin n_fail++; $display("FAIL ovf_write%0d got wea=%b addr=%0d din=%h exp 1/%0d/%h", i, mem_wea, mem_addra, mem_dina, i, d); end
         end else begin
            n_cmp++; if (mem_wea !== 1'b0 || nent_we !== '0) begin n_fail++; $display("FAIL ovf_drop%0d got wea=%b we=%b exp 0/0", i, mem_wea, nent_we); end
         end
         n_cmp++; if (overflow !== (i >= CAP)) begin n_fail++; $display("FAIL ovf_flag%0d got=%b exp=%b", i, overflow, (i >= CAP)); end
      end
      n_cmp++; if (nent_i[7:0] !== 8'd128) begin n_fail++; $display("FAIL ovf_count got=%0d exp=128", nent_i[7:0]); end
      cycle(1'b1, 1'b1, 18'h7, 1'b1, 18'h8);
      n_cmp++; if (obs_rdy0 !== 1'b0 || obs_rdy1 !== 1'b0) begin n_fail++; $display("FAIL ovf_bx_ready got=%b%b exp=00", obs_rdy0, obs_rdy1); end
      n_cmp++; if (page_o !== 3'd1 || overflow !== 1'b0 || mem_wea !== 1'b0) begin n_fail++; $display("FAIL ovf_bx_state got page=%0d ovf=%b wea=%b exp 1/0/0", page_o, overflow, mem_wea); end
      n_cmp++; if (nent_we !== 8'b0000_0010 || nent_i[15:8] !== 8'd0 || nent_i[7:0] !== 8'd128) begin n_fail++; $display("FAIL ovf_bx_nent got we=%b c1=%0d c0=%0d exp 00000010/0/128", nent_we, nent_i[15:8], nent_i[7:0]); end
      $display("test_overflow done");
   endtask

   task automatic test_page_wrap();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 1'b0, 18'h0, 1'b0, 18'h0);
         n_cmp++; if (page_o !== 3'(i % 8) || nent_we !== (8'b1 << (i % 8))) begin n_fail++; $display("FAIL wrap_step%0d got page=%0d we=%b exp %0d", i, page_o, nent_we, i % 8); end
      end
      cycle(1'b0, 1'b0, 18'h0, 1'b1, 18'h33);
      n_cmp++; if (mem_wea !== 1'b1 || mem_addra !== '0 || mem_dina !== 18'h33 || nent_i[7:0] !== 8'd1) begin n_fail++; $display("FAIL wrap_write got wea=%b addr=%0d din=%h cnt=%0d exp 1/0/33/1", mem_wea, mem_addra, mem_dina, nent_i[7:0]); end
      $display("test_page_wrap done");
   endtask

   task automatic test_bx_after_xfer();
      do_reset();
      cycle(1'b0, 1'b1, 18'h11, 1'b0, 18'h0);
      n_cmp++; if (mem_wea !== 1'b1 || mem_addra !== '0 || mem_dina !== 18'h11) begin n_fail++; $display("FAIL bxx_old got wea=%b addr=%0d din=%h exp 1/0/11", mem_wea, mem_addra, mem_dina); end
      cycle(1'b1, 1'b1, 18'h22, 1'b1, 18'h23);
      n_cmp++; if (obs_rdy0 !== 1'b0 || obs_rdy1 !== 1'b0 || mem_wea !== 1'b0) begin n_fail++; $display("FAIL bxx_gate got rdy=%b%b wea=%b exp 00/0", obs_rdy0, obs_rdy1, mem_wea); end
      cycle(1'b0, 1'b1, 18'h44, 1'b0, 18'h0);
      n_cmp++; if (mem_wea !== 1'b1 || mem_addra !== 10'd128 || mem_dina !== 18'h44) begin n_fail++; $display("FAIL bxx_new got wea=%b addr=%0d din=%h exp 1/128/44", mem_wea, mem_addra, mem_dina); end
      $display("test_bx_after_xfer done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      cycle(1'b0, 1'b1, 18'h55, 1'b0, 18'h0);
      n_cmp++; if (mem_wea !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got wea=%b exp=1", mem_wea); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (mem_wea !== 1'b0 || mem_addra !== '0 || mem_dina !== '0 || nent_we !== '0 || nent_i !== '0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_async got wea=%b addr=%0d din=%h we=%b nent=%h rdy=%b%b exp all 0", mem_wea, mem_addra, mem_dina, nent_we, nent_i, in0_ready, in1_ready); end
      @(posedge clk); #1;
      n_cmp++; if (mem_wea !== 1'b0 || page_o !== '0) begin n_fail++; $display("FAIL rmid_hold got wea=%b page=%0d exp 0/0", mem_wea, page_o); end
      in0_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      cycle(1'b0, 1'b0, 18'h0, 1'b0, 18'h0);
      n_cmp++; if (mem_wea !== 1'b0 || page_o !== '0) begin n_fail++; $display("FAIL rmid_release got wea=%b page=%0d exp 0/0", mem_wea, page_o); end
      cycle(1'b0, 1'b1, 18'h66, 1'b0, 18'h0);
      n_cmp++; if (mem_wea !== 1'b1 || mem_addra !== '0 || mem_dina !== 18'h66) begin n_fail++; $display("FAIL rmid_first got wea=%b addr=%0d din=%h exp 1/0/66", mem_wea, mem_addra, mem_dina); end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7), 18'($urandom),
               ($urandom_range(0, 9) < 7), 18'($urandom));
         n_cmp++; if (obs_rdy0 !== exp_rdy0 || obs_rdy1 !== exp_rdy1) begin n_fail++; bad++; $display("FAIL rand_ready%0d got=%b%b exp=%b%b", i, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1); end
         n_cmp++; if (mem_wea !== e_wea || (e_wea && (mem_addra !== 10'(e_addr) || mem_dina !== e_din))) begin n_fail++; bad++; $display("FAIL rand_write%0d got wea=%b addr=%0d din=%h exp %b/%0d/%h", i, mem_wea, mem_addra, mem_dina, e_wea, e_addr, e_din); end
         n_cmp++; if (nent_we !== e_we || nent_i !== model_nent()) begin n_fail++; bad++; $display("FAIL rand_nent%0d got we=%b nent=%h exp %b/%h", i, nent_we, nent_i, e_we, model_nent()); end
         n_cmp++; if (page_o !== 3'(m_page) || overflow !== m_ovf) begin n_fail++; bad++; $display("FAIL rand_state%0d got page=%0d ovf=%b exp %0d/%b", i, page_o, overflow, m_page, m_ovf); end
         if (bad > 20) break;
      end
      $display("test_random done");
   endtask

   initial begin
      rst_n = 1'b0;
      bx_start = 0; in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0;
      model_reset();
      test_reset();
      test_single();
      test_alternate();
      test_overflow();
      test_page_wrap();
      test_bx_after_xfer();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_write_arbiter.md
MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 18, width of each stored word.
REQ-002 SHALL have parameter PAGE_BITS, default 3, log2 of the page count (8 pages).
REQ-003 SHALL have parameter ENT_BITS, default 7, log2 of entries per page (128).
REQ-004 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  bx_start  in  1  pulse; advance to the next page (new event).
  in0_valid  in  1  requester 0 has data.
  in0_data  in  RAM_WIDTH  requester 0 word.
  in0_ready  out  1  requester 0 word accepted this cycle.
  in1_valid, in1_data, in1_ready  same widths and meanings for requester 1.
  mem_wea  out  1  memory write enable.
  mem_addra  out  PAGE_BITS+ENT_BITS  memory write address {page, entry}.
  mem_dina  out  RAM_WIDTH  memory write data.
  nent_we  out  2^PAGE_BITS  per-page entry-count write enable.
  nent_i  out  8*2^PAGE_BITS  per-page entry counts; page p occupies bits [8p+7:8p].
  page_o  out  PAGE_BITS  current write page.
  overflow  out  1  sticky: at least one word was dropped on the current page.

Function
REQ-005 SHALL keep the page pointer, one ENT_BITS+1-bit counter per page, a round-robin pointer and the overflow flag as registers.
REQ-006 Transfer rule: a transfer occurs on requester k when ink_valid and ink_ready are both 1 at a rising edge of clk.
REQ-007 Cycle with bx_start=1: SHALL drive in0_ready=in1_ready=0.
REQ-008 Cycle with bx_start=1: SHALL set page to (page+1) mod 2^PAGE_BITS.
REQ-009 Cycle with bx_start=1: SHALL clear the new page's counter.
REQ-010 Cycle with bx_start=1: SHALL clear overflow.
REQ-011 Cycle with bx_start=1: SHALL, in the next cycle, pulse nent_we for the new page with count 0.
REQ-012 Arbitration, bx_start=0, only one requester valid: SHALL assert only that requester's ready.
REQ-013 Arbitration, bx_start=0, both requesters valid: SHALL assert ready only for the requester that was not granted last.
REQ-014 Arbitration, bx_start=0, neither requester valid: ready SHALL be 1 for the requester favoured by the round-robin pointer, 0 for the other.
REQ-015 The round-robin pointer SHALL update only on a transfer.
REQ-016 Transfer at cycle N, page not full (counter < 2^ENT_BITS): SHALL drive, at cycle N+1, mem_wea=1, mem_addra={page, counter}, mem_dina=the accepted data.
REQ-017 Transfer at cycle N, page not full: SHALL, at cycle N+1, pulse nent_we[page]=1 and drive that page's nent_i field to counter+1.
REQ-018 Transfer at cycle N, page not full: SHALL increment the counter at the same edge that accepts the transfer.
REQ-019 Transfer, page full (counter = 2^ENT_BITS): ready SHALL still follow REQ-012..014, the word SHALL be discarded, mem_wea and nent_we SHALL stay 0, and overflow SHALL be set.
REQ-020 Latency SHALL be exactly 1 cycle from transfer to mem_wea; throughput SHALL be one write per cycle, with no bubble between back-to-back transfers.
REQ-021 The counter SHALL never exceed 2^ENT_BITS (saturating, no wrap).
REQ-022 The page pointer SHALL wrap from 2^PAGE_BITS-1 to 0.
REQ-023 nent_i SHALL continuously present all page counters; count values SHALL be zero-extended to 8 bits.
REQ-024 A write registered in the cycle before bx_start SHALL still complete to the old page.
REQ-025 page_o SHALL equal the page pointer register.

Reset
REQ-026 On rst_n=0, immediately and asynchronously:
  - page=0;
  - all counters=0;
  - round-robin pointer favours in0;
  - overflow=0;
  - mem_wea=0, nent_we=0, mem_addra=0, mem_dina=0;
  - in0_ready=in1_ready=0 while rst_n=0.
REQ-027 A write registered before rst_n falls SHALL be dropped (mem_wea=0); no write SHALL occur until the first transfer after release.

Verification
REQ-028 Reset release; in0_valid=1 with data 0x00A5 for 1 cycle -> next cycle mem_wea=1, mem_addra=0, mem_dina=0x00A5, nent_we=8'b0000_0001, nent_i[7:0]=1.
REQ-029 Both valid continuously for 4 cycles (in0 0x1, in1 0x2) -> writes in order in0,in1,in0,in1 at addresses 0..3; final nent_i[7:0]=4.
REQ-030 130 transfers on page 0 -> 128 writes to addresses 0..127, nent_i[7:0]=128, overflow=1 after the 129th transfer; bx_start -> page_o=1, overflow=0, nent_we[1] pulses with nent_i[15:8]=0.
REQ-031 bx_start pulsed 8 times with no data -> page_o steps 1..7,0; transfer then writes address 0 and nent_i[7:0]=1.
REQ-032 Transfer at cycle N with bx_start=1 at N+1 -> write at N+1 uses the old page and both readies=0 at N+1; the next transfer writes {new page, 0}.
REQ-033 rst_n=0 asserted the cycle after a transfer -> no mem_wea; all outputs 0 during reset; page_o=0 after release.
